// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : fetch_unit
// Description : SimpleRISC instruction-fetch stage: fetch PC, 1-cycle imem
//               interface, IF/OF register with one-entry stall hold buffer.
// Revision    : 1.0 - initial release
// =============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h6800_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    input  logic        stall,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid
);

    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic        rsp_pending_q, rsp_pending_d;
    logic [31:0] rsp_pc_q,      rsp_pc_d;
    logic        hold_valid_q,  hold_valid_d;
    logic [31:0] hold_inst_q,   hold_inst_d;
    logic [31:0] hold_pc_q,     hold_pc_d;
    logic [31:0] inst_q,        inst_d;
    logic [31:0] pc_q,          pc_d;
    logic        valid_q,       valid_d;

    // Word alignment is forced on redirect targets, so the low bits are dropped.
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = &{1'b0, branchPC[1:0]};

    assign imem_en    = !stall && !isBranchTaken;
    assign imem_addr  = fetch_pc_q;
    assign inst_out   = inst_q;
    assign pc_out     = pc_q;
    assign inst_valid = valid_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pending_d = rsp_pending_q;
        rsp_pc_d      = rsp_pc_q;
        hold_valid_d  = hold_valid_q;
        hold_inst_d   = hold_inst_q;
        hold_pc_d     = hold_pc_q;
        inst_d        = inst_q;
        pc_d          = pc_q;
        valid_d       = valid_q;

        if (isBranchTaken) begin
            // Redirect squashes everything in flight, stalled or not.
            valid_d       = 1'b0;
            inst_d        = NOP_INST;
            hold_valid_d  = 1'b0;
            rsp_pending_d = 1'b0;
            fetch_pc_d    = {branchPC[31:2], 2'b00};
        end else if (stall) begin
            if (rsp_pending_q) begin
                hold_valid_d = 1'b1;
                hold_inst_d  = imem_rdata;
                hold_pc_d    = rsp_pc_q;
            end
            rsp_pending_d = 1'b0;
        end else begin
            if (hold_valid_q) begin
                inst_d  = hold_inst_q;
                pc_d    = hold_pc_q;
                valid_d = 1'b1;
            end else if (rsp_pending_q) begin
                inst_d  = imem_rdata;
                pc_d    = rsp_pc_q;
                valid_d = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
            hold_valid_d  = 1'b0;
            rsp_pending_d = 1'b1;
            rsp_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pending_q <= 1'b0;
            rsp_pc_q      <= 32'h0;
            hold_valid_q  <= 1'b0;
            hold_inst_q   <= 32'h0;
            hold_pc_q     <= 32'h0;
            inst_q        <= NOP_INST;
            pc_q          <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_pc_q      <= rsp_pc_d;
            hold_valid_q  <= hold_valid_d;
            hold_inst_q   <= hold_inst_d;
            hold_pc_q     <= hold_pc_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : tb_fetch_unit
// Description : Directed, table-driven self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_NOP = 32'h6800_0000;

    logic        clk;
    logic        rst;
    logic        isBranchTaken;
    logic [31:0] branchPC;
    logic        stall;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (C_NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .isBranchTaken (isBranchTaken),
        .branchPC      (branchPC),
        .stall         (stall),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .inst_valid    (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word is a scrambled copy of its address so inst and pc differ.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    initial imem_rdata = 32'h0;
    always @(posedge clk) if (imem_en) imem_rdata <= inst_of(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && !stall) begin
            n_checks++;
            if (dut.hold_valid_q && dut.rsp_pending_q) begin
                n_fail++;
                $display("FAIL invariant: hold_valid and rsp_pending both set at %0t", $time);
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bpc;
        logic        en;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bp,
                                input logic e, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t r;
        r.stall = s; r.br = b; r.bpc = bp; r.en = e; r.addr = a; r.v = v; r.pc = p;
        return r;
    endfunction

    task automatic check_outs(input string tag, input logic e_en, input logic [31:0] e_addr,
                              input logic e_v, input logic [31:0] e_pc);
        check({tag, ".imem_en"},    {31'h0, imem_en},    {31'h0, e_en});
        check({tag, ".imem_addr"},  imem_addr,           e_addr);
        check({tag, ".inst_valid"}, {31'h0, inst_valid}, {31'h0, e_v});
        check({tag, ".pc_out"},     pc_out,              e_pc);
        check({tag, ".inst_out"},   inst_out,            e_v ? inst_of(e_pc) : C_NOP);
    endtask

    initial begin
        // Expected state is what the cycle starts with; inputs apply to that cycle.
        vecs.push_back(mk(0,0,32'h0,        1,32'h0,        0,32'h0));   // c0
        vecs.push_back(mk(0,0,32'h0,        1,32'h4,        0,32'h0));
        vecs.push_back(mk(0,0,32'h0,        1,32'h8,        1,32'h0));
        vecs.push_back(mk(1,0,32'h0,        0,32'hC,        1,32'h4));   // stall, pc8 in flight
        vecs.push_back(mk(1,0,32'h0,        0,32'hC,        1,32'h4));
        vecs.push_back(mk(1,0,32'h0,        0,32'hC,        1,32'h4));
        vecs.push_back(mk(0,0,32'h0,        1,32'hC,        1,32'h4));
        vecs.push_back(mk(0,0,32'h0,        1,32'h10,       1,32'h8));
        vecs.push_back(mk(0,0,32'h0,        1,32'h14,       1,32'hC));
        vecs.push_back(mk(0,1,32'h103,      0,32'h18,       1,32'h10));  // branch N
        vecs.push_back(mk(0,0,32'h0,        1,32'h100,      0,32'h10));
        vecs.push_back(mk(0,0,32'h0,        1,32'h104,      0,32'h10));
        vecs.push_back(mk(0,0,32'h0,        1,32'h108,      1,32'h100)); // N+3
        vecs.push_back(mk(1,0,32'h0,        0,32'h10C,      1,32'h104)); // fills hold
        vecs.push_back(mk(1,1,32'h200,      0,32'h10C,      1,32'h104)); // branch in stall
        vecs.push_back(mk(1,0,32'h0,        0,32'h200,      0,32'h104));
        vecs.push_back(mk(0,0,32'h0,        1,32'h200,      0,32'h104));
        vecs.push_back(mk(0,0,32'h0,        1,32'h204,      0,32'h104));
        vecs.push_back(mk(0,1,32'h300,      0,32'h208,      1,32'h200)); // back-to-back branch
        vecs.push_back(mk(0,1,32'h401,      0,32'h300,      0,32'h200));
        vecs.push_back(mk(0,0,32'h0,        1,32'h400,      0,32'h200));
        vecs.push_back(mk(0,0,32'h0,        1,32'h404,      0,32'h200));
        vecs.push_back(mk(0,0,32'h0,        1,32'h408,      1,32'h400));
        vecs.push_back(mk(0,1,32'hFFFF_FFF8,0,32'h40C,      1,32'h404)); // wrap test
        vecs.push_back(mk(0,0,32'h0,        1,32'hFFFF_FFF8,0,32'h404));
        vecs.push_back(mk(0,0,32'h0,        1,32'hFFFF_FFFC,0,32'h404));
        vecs.push_back(mk(0,0,32'h0,        1,32'h0,        1,32'hFFFF_FFF8));
        vecs.push_back(mk(0,0,32'h0,        1,32'h4,        1,32'hFFFF_FFFC));
        vecs.push_back(mk(0,0,32'h0,        1,32'h8,        1,32'h0));

        rst = 1'b1; stall = 1'b0; isBranchTaken = 1'b0; branchPC = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.inst_valid", {31'h0, inst_valid}, 32'h0);
        check("reset.inst_out",   inst_out,            C_NOP);
        check("reset.pc_out",     pc_out,              32'h0);
        check("reset.imem_addr",  imem_addr,           32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall; isBranchTaken = vecs[i].br; branchPC = vecs[i].bpc;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].v, vecs[i].pc);
            @(negedge clk);
        end

        // Here fetch_pc=0xC and the response for pc 8 is pending; pulse reset mid-cycle.
        stall = 1'b0; isBranchTaken = 1'b0; branchPC = 32'h0;
        #2 rst = 1'b1;
        #1;
        check("async_rst.inst_valid", {31'h0, inst_valid}, 32'h0);
        check("async_rst.inst_out",   inst_out,            C_NOP);
        check("async_rst.pc_out",     pc_out,              32'h0);
        check("async_rst.imem_addr",  imem_addr,           32'h0);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check_outs("post_rst0", 1'b1, 32'h4, 1'b0, 32'h0);
        @(negedge clk); #1;
        check_outs("post_rst1", 1'b1, 32'h8, 1'b1, 32'h0);
        @(negedge clk); #1;
        check_outs("post_rst2", 1'b1, 32'hC, 1'b1, 32'h4);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
